// File: rtl/matmul_host_sequencer_if.sv
// ---------------------------------------------------------------------------
// matmul_host_sequencer_if
//   Bundles every handshake and bus signal of the matmul host sequencer:
//   the host command channel, the host load/read data channels, the status
//   outputs and the wires that go to/come from the 4x4 matmul wrapper.
//
//   modport master : the sequencer (drives cmd_ready, in_ready, out_*,
//                    status and all wrapper control/data inputs)
//   modport slave  : the environment (host plus wrapper)
//
//   Host command : cmd_valid, cmd_ready, cmd_op, cmd_base, cmd_len
//   Host load    : in_valid, in_ready, in_data
//   Host read    : out_valid, out_data, out_last
//   Status       : cmd_done, err_timeout
//   Wrapper      : addr_pi, data_pi, we_a, we_b, we_c,
//                  enable_writing_to_mem, enable_reading_from_mem,
//                  start_mat_mul, done_mat_mul, data_from_out_mat
// ---------------------------------------------------------------------------
interface matmul_host_sequencer_if #(
    parameter int DWIDTH          = 8,
    parameter int BB_MAT_MUL_SIZE = 4,
    parameter int AWIDTH          = 7
) ();
    localparam int RW = BB_MAT_MUL_SIZE * DWIDTH;

    // host command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [AWIDTH-1:0] cmd_base;
    logic [AWIDTH:0]   cmd_len;

    // host load channel
    logic              in_valid;
    logic              in_ready;
    logic [RW-1:0]     in_data;

    // host read channel
    logic              out_valid;
    logic [RW-1:0]     out_data;
    logic              out_last;

    // status
    logic              cmd_done;
    logic              err_timeout;

    // wrapper side
    logic [AWIDTH-1:0] addr_pi;
    logic [RW-1:0]     data_pi;
    logic              we_a;
    logic              we_b;
    logic              we_c;
    logic              enable_writing_to_mem;
    logic              enable_reading_from_mem;
    logic              start_mat_mul;
    logic              done_mat_mul;
    logic [RW-1:0]     data_from_out_mat;

    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_len,
        input  in_valid, in_data,
        input  done_mat_mul, data_from_out_mat,
        output cmd_ready, in_ready,
        output out_valid, out_data, out_last,
        output cmd_done, err_timeout,
        output addr_pi, data_pi, we_a, we_b, we_c,
        output enable_writing_to_mem, enable_reading_from_mem, start_mat_mul
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_len,
        output in_valid, in_data,
        output done_mat_mul, data_from_out_mat,
        input  cmd_ready, in_ready,
        input  out_valid, out_data, out_last,
        input  cmd_done, err_timeout,
        input  addr_pi, data_pi, we_a, we_b, we_c,
        input  enable_writing_to_mem, enable_reading_from_mem, start_mat_mul
    );
endinterface

// File: rtl/matmul_host_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_host_sequencer
//   Command-driven controller that drives the 4x4 matmul-with-memories
//   wrapper for a host. Four commands: LOAD_A, LOAD_B (write rows of A/B),
//   RUN (start the multiply and wait for done with a timeout) and READ_C
//   (stream rows of C back to the host). The wrapper writes data WR_SKEW
//   cycles after the address and returns read data RD_LAT cycles after the
//   address; both skews are absorbed by small shift pipes here.
//
//   Ports:
//     clk   - single clock (also feeds wrapper clk / clk_mem externally)
//     reset - synchronous, active-high
//     bus   - matmul_host_sequencer_if.master (host + wrapper signals)
// ---------------------------------------------------------------------------
module matmul_host_sequencer #(
    parameter int DWIDTH          = 8,
    parameter int BB_MAT_MUL_SIZE = 4,
    parameter int AWIDTH          = 7,
    parameter int WR_SKEW         = 2,
    parameter int RD_LAT          = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    matmul_host_sequencer_if.master    bus
);
    localparam int RW  = BB_MAT_MUL_SIZE * DWIDTH;
    localparam int LW  = AWIDTH + 1;
    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DRW = $clog2(WR_SKEW + 2);

    localparam logic [LW-1:0]  LEN_ONE   = LW'(1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DRW-1:0] DRN_ONE   = DRW'(1);
    localparam logic [DRW-1:0] DRN_LIMIT = DRW'(WR_SKEW);

    localparam logic [1:0] OP_LOAD_A = 2'd0;
    localparam logic [1:0] OP_LOAD_B = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_DRAIN,
        S_RUN,
        S_READ,
        S_READ_DRAIN
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic               r_sel_b;      // 1 = LOAD_B target, 0 = LOAD_A
    logic [AWIDTH-1:0]  r_base;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_idx;
    logic [CW-1:0]      r_run_cnt;
    logic [DRW-1:0]     r_drain_cnt;
    logic               r_cmd_done;
    logic               r_err_timeout;

    // ---------------------------------------------------------------------
    // Next-state / combinational outputs
    // ---------------------------------------------------------------------
    state_t             w_state_next;
    logic [LW-1:0]      w_idx_next;
    logic [CW-1:0]      w_run_cnt_next;
    logic [DRW-1:0]     w_drain_next;
    logic               w_cmd_done_next;
    logic               w_err_next;
    logic               w_accept;
    logic               w_beat;
    logic               w_rd_issue;
    logic               w_rd_last_in;
    logic [AWIDTH-1:0]  w_addr;
    logic               w_cmd_ready;
    logic               w_in_ready;
    logic               w_en_wr;
    logic               w_en_rd;
    logic               w_start;

    logic [LW-1:0]      w_idx_inc;
    logic [AWIDTH-1:0]  w_row_addr;
    logic               w_out_valid;
    logic               w_out_last;
    logic               w_wr_vld;
    logic               w_wr_sel;
    logic [RW-1:0]      w_wr_data;

    assign w_idx_inc  = r_idx + LEN_ONE;
    // Truncation to AWIDTH bits gives the modulo-2^AWIDTH wrap for free.
    assign w_row_addr = r_base + r_idx[AWIDTH-1:0];

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_run_cnt_next  = r_run_cnt;
        w_drain_next    = r_drain_cnt;
        w_cmd_done_next = 1'b0;
        w_err_next      = r_err_timeout;
        w_accept        = 1'b0;
        w_beat          = 1'b0;
        w_rd_issue      = 1'b0;
        w_rd_last_in    = 1'b0;
        w_addr          = '0;
        w_cmd_ready     = 1'b0;
        w_in_ready      = 1'b0;
        w_en_wr         = 1'b0;
        w_en_rd         = 1'b0;
        w_start         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept       = 1'b1;
                    w_err_next     = 1'b0;
                    w_idx_next     = '0;
                    w_run_cnt_next = '0;
                    w_drain_next   = '0;
                    if (bus.cmd_op == OP_RUN) begin
                        w_state_next = S_RUN;
                    end else if (bus.cmd_len == '0) begin
                        // Empty transfer: complete at once, touch no memory.
                        w_cmd_done_next = 1'b1;
                    end else if (bus.cmd_op == OP_LOAD_A || bus.cmd_op == OP_LOAD_B) begin
                        w_state_next = S_LOAD;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end

            S_LOAD: begin
                w_en_wr    = 1'b1;
                w_in_ready = (r_idx < r_len);
                if (w_in_ready && bus.in_valid) begin
                    w_beat     = 1'b1;
                    w_addr     = w_row_addr;
                    w_idx_next = w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        w_state_next = S_LOAD_DRAIN;
                    end
                end
            end

            S_LOAD_DRAIN: begin
                // Keep the write path enabled until the skewed data has landed.
                w_en_wr = 1'b1;
                if (r_drain_cnt == DRN_LIMIT) begin
                    w_state_next    = S_IDLE;
                    w_cmd_done_next = 1'b1;
                end else begin
                    w_drain_next = r_drain_cnt + DRN_ONE;
                end
            end

            S_RUN: begin
                w_start = 1'b1;
                // done is tested first so it wins over a coincident timeout.
                if (bus.done_mat_mul) begin
                    w_state_next    = S_IDLE;
                    w_cmd_done_next = 1'b1;
                end else if (r_run_cnt == CNT_LIMIT) begin
                    w_state_next    = S_IDLE;
                    w_cmd_done_next = 1'b1;
                    w_err_next      = 1'b1;
                end else begin
                    w_run_cnt_next = r_run_cnt + CNT_ONE;
                end
            end

            S_READ: begin
                w_en_rd      = 1'b1;
                w_rd_issue   = 1'b1;
                w_addr       = w_row_addr;
                w_idx_next   = w_idx_inc;
                w_rd_last_in = (w_idx_inc == r_len);
                if (w_idx_inc == r_len) begin
                    w_state_next = S_READ_DRAIN;
                end
            end

            S_READ_DRAIN: begin
                // The final row leaving the pipe empties it; completion is
                // signalled combinationally alongside out_last.
                w_en_rd = 1'b1;
                if (w_out_last) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sel_b       <= 1'b0;
            r_base        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_run_cnt     <= '0;
            r_drain_cnt   <= '0;
            r_cmd_done    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_run_cnt     <= w_run_cnt_next;
            r_drain_cnt   <= w_drain_next;
            r_cmd_done    <= w_cmd_done_next;
            r_err_timeout <= w_err_next;
            if (w_accept) begin
                r_sel_b <= bus.cmd_op[0];
                r_base  <= bus.cmd_base;
                r_len   <= bus.cmd_len;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Write skew pipe: row data and target select travel WR_SKEW stages so
    // that data_pi/we_x line up with the wrapper's delayed address.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WR_SKEW; gi++) begin : g_wr
            logic          r_vld;
            logic          r_sel;
            logic [RW-1:0] r_data;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld  <= 1'b0;
                        r_sel  <= 1'b0;
                        r_data <= '0;
                    end else begin
                        r_vld  <= w_beat;
                        r_sel  <= w_beat & r_sel_b;
                        r_data <= w_beat ? bus.in_data : '0;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld  <= 1'b0;
                        r_sel  <= 1'b0;
                        r_data <= '0;
                    end else begin
                        r_vld  <= g_wr[gi-1].r_vld;
                        r_sel  <= g_wr[gi-1].r_sel;
                        r_data <= g_wr[gi-1].r_data;
                    end
                end
            end
        end
    endgenerate

    assign w_wr_vld  = g_wr[WR_SKEW-1].r_vld;
    assign w_wr_sel  = g_wr[WR_SKEW-1].r_sel;
    assign w_wr_data = g_wr[WR_SKEW-1].r_data;

    // ---------------------------------------------------------------------
    // Read latency pipe: one valid bit and one last bit per outstanding
    // address, so returning wrapper data can be qualified RD_LAT later.
    // ---------------------------------------------------------------------
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd
            logic r_vld;
            logic r_last;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld  <= 1'b0;
                        r_last <= 1'b0;
                    end else begin
                        r_vld  <= w_rd_issue;
                        r_last <= w_rd_last_in;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld  <= 1'b0;
                        r_last <= 1'b0;
                    end else begin
                        r_vld  <= g_rd[gi-1].r_vld;
                        r_last <= g_rd[gi-1].r_last;
                    end
                end
            end
        end
    endgenerate

    assign w_out_valid = g_rd[RD_LAT-1].r_vld;
    assign w_out_last  = g_rd[RD_LAT-1].r_vld & g_rd[RD_LAT-1].r_last;

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // cmd_ready is masked by reset so it reads 0 while reset is held.
    assign bus.cmd_ready               = w_cmd_ready & ~reset;
    assign bus.in_ready                = w_in_ready;
    assign bus.out_valid               = w_out_valid;
    assign bus.out_data                = w_out_valid ? bus.data_from_out_mat : '0;
    assign bus.out_last                = w_out_last;
    assign bus.cmd_done                = r_cmd_done | w_out_last;
    assign bus.err_timeout             = r_err_timeout;
    assign bus.addr_pi                 = w_addr;
    assign bus.data_pi                 = w_wr_data;
    assign bus.we_a                    = w_wr_vld & ~w_wr_sel;
    assign bus.we_b                    = w_wr_vld & w_wr_sel;
    assign bus.we_c                    = w_start;
    assign bus.enable_writing_to_mem   = w_en_wr;
    assign bus.enable_reading_from_mem = w_en_rd;
    assign bus.start_mat_mul           = w_start;

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_host_sequencer
//   Scoreboard bench: the stimulus tasks push expected addresses, writes and
//   read rows into queues; a negedge monitor pops and compares them as the
//   sequencer produces them. A small wrapper model returns addr+0x100 with a
//   4-cycle latency for reads.
// ---------------------------------------------------------------------------
module tb_matmul_host_sequencer;
    localparam int DW      = 8;
    localparam int BB      = 4;
    localparam int AW      = 7;
    localparam int RW      = BB * DW;
    localparam int WR_SKEW = 2;
    localparam int RD_LAT  = 4;
    localparam int TO      = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matmul_host_sequencer_if #(.DWIDTH(DW), .BB_MAT_MUL_SIZE(BB), .AWIDTH(AW)) bus ();

    matmul_host_sequencer #(
        .DWIDTH(DW), .BB_MAT_MUL_SIZE(BB), .AWIDTH(AW),
        .WR_SKEW(WR_SKEW), .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = 0x%0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    // wrapper read model: data returns RD_LAT cycles after the address
    logic [AW-1:0] hist [RD_LAT];
    always @(posedge clk) begin
        hist[0] <= bus.addr_pi;
        for (int i = 1; i < RD_LAT; i++) hist[i] <= hist[i-1];
    end
    assign bus.data_from_out_mat = {{(RW-AW){1'b0}}, hist[RD_LAT-1]} + RW'(32'h100);

    // scoreboards
    typedef struct {
        logic [RW-1:0] data;
        logic          last;
        int            at;
    } rd_t;
    logic [AW-1:0] exp_addr_q [$];
    logic [RW:0]   exp_wr_q   [$];   // {sel_b, data}
    int            beat_cyc_q [$];
    rd_t           exp_rd_q   [$];
    int wr_seen   = 0;
    int rd_seen   = 0;
    int start_cnt = 0;
    int wec_cnt   = 0;

    logic [RW:0] m_wr;
    int          m_bc;
    rd_t         m_rd;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) begin
                if (exp_addr_q.size() == 0) check_eq("beat_unexpected", 1, 0);
                else check_eq("addr_pi", 64'(bus.addr_pi), 64'(exp_addr_q.pop_front()));
                beat_cyc_q.push_back(cyc);
            end
            if (bus.we_a || bus.we_b) begin
                wr_seen++;
                if (exp_wr_q.size() == 0 || beat_cyc_q.size() == 0) begin
                    check_eq("write_unexpected", 1, 0);
                end else begin
                    m_wr = exp_wr_q.pop_front();
                    m_bc = beat_cyc_q.pop_front();
                    check_eq("data_pi", 64'(bus.data_pi), 64'(m_wr[RW-1:0]));
                    check_eq("we_b_we_a", 64'({bus.we_b, bus.we_a}), m_wr[RW] ? 64'd2 : 64'd1);
                    check_eq("wr_skew", 64'(cyc - m_bc), 64'(WR_SKEW));
                end
            end
            if (bus.out_valid) begin
                rd_seen++;
                if (exp_rd_q.size() == 0) begin
                    check_eq("out_unexpected", 1, 0);
                end else begin
                    m_rd = exp_rd_q.pop_front();
                    check_eq("out_data", 64'(bus.out_data), 64'(m_rd.data));
                    check_eq("out_last", 64'(bus.out_last), 64'(m_rd.last));
                    check_eq("out_cycle", 64'(cyc), 64'(m_rd.at));
                    check_eq("done_with_last", 64'(bus.cmd_done), 64'(m_rd.last));
                end
            end
            if (bus.start_mat_mul) start_cnt++;
            if (bus.we_c) wec_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] base,
                            input logic [AW:0] len, output int acc);
        bit got;
        got = 0;
        acc = -1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = cyc;
                got = 1;
                break;
            end
        end
        if (!got) check_eq("cmd_ready_wait_expired", 0, 1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_rows(input logic [AW-1:0] base, input int n, input logic sel_b,
                             input logic [RW-1:0] seed, input int gap_after, input int gap_len,
                             input bit b2b, input int acc, output int last_beat);
        logic [RW-1:0] d;
        logic [AW-1:0] a;
        bit got;
        last_beat = -1;
        for (int i = 0; i < n; i++) begin
            if (i == gap_after) begin
                bus.in_valid = 1'b0;
                repeat (gap_len) step();
            end
            d = seed + RW'(32'h04040404 * i);
            a = base + AW'(i);
            bus.in_data  = d;
            bus.in_valid = 1'b1;
            exp_addr_q.push_back(a);
            exp_wr_q.push_back({sel_b, d});
            got = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    got = 1;
                    break;
                end
            end
            if (!got) check_eq("in_ready_wait_expired", 0, 1);
            if (b2b) check_eq("beat_cycle", 64'(cyc), 64'(acc + 1 + i));
            last_beat = cyc;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.cmd_done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check_eq("done_wait_expired", 0, 1);
        step();
    endtask

    int acc, lb, dc, s, ws, ov, cd;

    initial begin
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = 2'd0;
        bus.cmd_base     = '0;
        bus.cmd_len      = 8'd4;
        bus.in_valid     = 1'b1;
        bus.in_data      = 32'hDEADBEEF;
        bus.done_mat_mul = 1'b0;

        // reset with live cmd_valid / in_valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs_zero",
                 64'(|{bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last,
                       bus.cmd_done, bus.err_timeout, bus.addr_pi, bus.data_pi, bus.we_a,
                       bus.we_b, bus.we_c, bus.enable_writing_to_mem,
                       bus.enable_reading_from_mem, bus.start_mat_mul}), 0);
        step();
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check_eq("cmd_ready_after_reset", 64'(bus.cmd_ready), 1);
        step();

        // LOAD_A base 0 len 4, back-to-back rows 0x04030201..
        send_cmd(2'd0, 7'd0, 8'd4, acc);
        send_rows(7'd0, 4, 1'b0, 32'h04030201, -1, 0, 1'b1, acc, lb);
        wait_done(20, dc);
        check_eq("loadA_done_cycle", 64'(dc), 64'(lb + WR_SKEW + 2));
        check_eq("loadA_writes_drained", 64'(exp_wr_q.size()), 0);

        // LOAD_B base 126 len 4, 3-cycle stall after the 2nd beat
        send_cmd(2'd1, 7'd126, 8'd4, acc);
        send_rows(7'd126, 4, 1'b1, 32'hA0B0C0D0, 2, 3, 1'b0, acc, lb);
        wait_done(20, dc);
        check_eq("loadB_done_cycle", 64'(dc), 64'(lb + WR_SKEW + 2));
        check_eq("loadB_writes_drained", 64'(exp_wr_q.size()), 0);

        // RUN with done 20 cycles after start
        start_cnt = 0;
        wec_cnt   = 0;
        send_cmd(2'd2, 7'd0, 8'd0, acc);
        s = acc + 1;
        @(negedge clk);
        check_eq("run_start_high", 64'(bus.start_mat_mul), 1);
        #4;
        repeat (20) step();
        bus.done_mat_mul = 1'b1;
        step();
        bus.done_mat_mul = 1'b0;
        wait_done(10, dc);
        check_eq("run_done_cycle", 64'(dc), 64'(s + 21));
        check_eq("run_start_cycles", 64'(start_cnt), 21);
        check_eq("run_we_c_cycles", 64'(wec_cnt), 21);
        check_eq("run_err_timeout", 64'(bus.err_timeout), 0);

        // RUN with no done: timeout abort
        start_cnt = 0;
        send_cmd(2'd2, 7'd0, 8'd0, acc);
        s = acc + 1;
        wait_done(100, dc);
        check_eq("timeout_done_cycle", 64'(dc), 64'(s + TO));
        check_eq("timeout_start_cycles", 64'(start_cnt), TO);
        check_eq("timeout_err_set", 64'(bus.err_timeout), 1);

        // READ_C base 0 len 4; also clears err_timeout on acceptance
        send_cmd(2'd3, 7'd0, 8'd4, acc);
        for (int i = 0; i < 4; i++)
            exp_rd_q.push_back('{data: RW'(32'h100 + i), last: (i == 3), at: acc + 1 + RD_LAT + i});
        @(negedge clk);
        check_eq("err_cleared_on_accept", 64'(bus.err_timeout), 0);
        #4;
        ws = rd_seen;
        wait_done(30, dc);
        check_eq("readC_done_cycle", 64'(dc), 64'(acc + 1 + RD_LAT + 3));
        check_eq("readC_rows_seen", 64'(rd_seen - ws), 4);
        check_eq("readC_queue_empty", 64'(exp_rd_q.size()), 0);

        // LOAD_A len 0: immediate done, no writes
        ws = wr_seen;
        send_cmd(2'd0, 7'd5, 8'd0, acc);
        wait_done(5, dc);
        check_eq("len0_done_cycle", 64'(dc), 64'(acc + 1));
        repeat (6) step();
        check_eq("len0_no_writes", 64'(wr_seen - ws), 0);

        // READ_C len 8, reset in the middle
        send_cmd(2'd3, 7'd10, 8'd8, acc);
        for (int i = 0; i < 8; i++)
            exp_rd_q.push_back('{data: RW'(32'h100 + 10 + i), last: (i == 7), at: acc + 1 + RD_LAT + i});
        repeat (6) step();
        reset = 1'b1;
        step();
        step();
        exp_rd_q.delete();
        reset = 1'b0;
        ov = 0;
        cd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) ov++;
            if (bus.cmd_done) cd++;
        end
        check_eq("abort_no_out_valid", 64'(ov), 0);
        check_eq("abort_no_cmd_done", 64'(cd), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
